// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle for mod_n_updown_counter; master drives controls, slave is the counter.
// Handshake: none -- every signal is level-sampled on each rising clk edge; tc is combinational.
interface mod_n_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] mod_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val, mod_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val, mod_val,
        output q, tc, wrap
    );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Run-time modulo-M up/down counter with load, enable and cascadable terminal count.
// Define MOD_N_UPDOWN_SAT_EN to build the saturating variant instead of wrap-around.
module mod_n_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mod_n_updown_counter_if.slave bus
);
    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_m_max;
    logic             w_degen;
    logic             w_at_top;
    logic             w_at_zero;
    logic             w_oob;
    logic             w_sat_step;

    // mod_val of 0 or 1 makes w_m_max meaningless; w_degen overrides every use of it.
    assign w_m_max   = bus.mod_val - WIDTH'(1);
    assign w_degen   = (bus.mod_val < WIDTH'(2));
    assign w_at_top  = (r_q >= w_m_max);
    assign w_at_zero = (r_q == '0);
    assign w_oob     = (r_q >= bus.mod_val);

`ifdef MOD_N_UPDOWN_SAT_EN
    logic r_held;

    // Remembers that the previous enabled step was already a saturating hold.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.load) begin
            r_held <= 1'b0;
        end else if (bus.en) begin
            r_held <= w_sat_step;
        end
    end
`endif

    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        w_sat_step = 1'b0;
        if (bus.load) begin
            w_q_nxt = (bus.load_val < bus.mod_val) ? bus.load_val : '0;
        end else if (bus.en) begin
            if (w_degen) begin
                w_q_nxt    = '0;
                w_wrap_nxt = 1'b1;
            end else if (bus.up_dn) begin
                if (!w_at_top) begin
                    w_q_nxt = r_q + WIDTH'(1);
                end else begin
`ifdef MOD_N_UPDOWN_SAT_EN
                    w_q_nxt    = w_m_max;
                    w_sat_step = (r_q == w_m_max);
                    w_wrap_nxt = w_sat_step && !r_held;
`else
                    w_q_nxt    = '0;
                    w_wrap_nxt = 1'b1;
`endif
                end
            end else if (w_oob) begin
                w_q_nxt = w_m_max;
            end else if (w_at_zero) begin
`ifdef MOD_N_UPDOWN_SAT_EN
                w_q_nxt    = '0;
                w_sat_step = 1'b1;
                w_wrap_nxt = !r_held;
`else
                w_q_nxt    = w_m_max;
                w_wrap_nxt = 1'b1;
`endif
            end else begin
                w_q_nxt = r_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bus.q    = r_q;
    assign bus.wrap = r_wrap;
    assign bus.tc   = bus.en && (w_degen || (bus.up_dn ? w_at_top : w_at_zero));
endmodule
